// File: rtl/video_frame_monitor.sv
// video_frame_monitor
// Passive tap on a pixel bus. It learns the sync polarity from the first
// data-enable edges, measures frame geometry and line period, flags changes
// in geometry and produces a per-channel checksum for every frame. It stops,
// or pulses, after FRAME_MAX frames.
//
// Ports:
//   opclk, oprst      pixel clock, async active-high reset
//   enable, clear     start monitoring / synchronous clear (same as reset)
//   in_vsync/hsync/de/data   tapped video bus (any sync polarity)
//   locked, vs_act    polarity detected / detected active vsync level
//   frame_cnt         completed frames
//   frame_width/height, htotal   last frame geometry and line period
//   csum, csum_valid  per-channel sums of the last frame, update strobe
//   geom_err, done    sticky geometry mismatch / frame limit reached
module video_frame_monitor #(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned NUM_D      = 3,
    parameter int unsigned FRAME_MAX  = 20,
    parameter int unsigned LOCK_EDGES = 3,
    parameter int unsigned HW         = 12,
    parameter int unsigned VW         = 12,
    parameter int unsigned CSUM_W     = 32,
    parameter              STOP_MODE  = "ONCE"
) (
    input  logic                      opclk,
    input  logic                      oprst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      in_vsync,
    input  logic                      in_hsync,
    input  logic                      in_de,
    input  logic [NUM_D*DSIZE-1:0]    in_data,
    output logic                      locked,
    output logic                      vs_act,
    output logic [15:0]               frame_cnt,
    output logic [HW-1:0]             frame_width,
    output logic [VW-1:0]             frame_height,
    output logic [HW-1:0]             htotal,
    output logic [NUM_D*CSUM_W-1:0]   csum,
    output logic                      csum_valid,
    output logic                      geom_err,
    output logic                      done
);

    localparam bit          WRAP_MODE = (STOP_MODE == "WRAP");
    localparam int unsigned EDGE_W    = $clog2(LOCK_EDGES + 1);
    localparam int unsigned MOD_W     = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    typedef enum logic [2:0] {IDLE, DETECT, WAIT_FRAME, ACTIVE, DONE} state_t;

    state_t state, state_next;

    logic                     enable_r, vsync_r, hsync_r, de_r;
    logic                     vsync_d, hsync_d, de_d;
    logic [NUM_D*DSIZE-1:0]   data_r;
    logic [EDGE_W-1:0]        edge_cnt;
    logic                     hs_act;
    logic [HW-1:0]            pix_cnt, line_w, h_cnt;
    logic [VW-1:0]            line_cnt;
    logic [NUM_D*CSUM_W-1:0]  acc;
    logic [MOD_W-1:0]         mod_cnt;

    logic                     de_rise, de_fall, frame_start, frame_end, hs_lead;
    logic                     line_done, line_bad, limit_hit;
    logic [HW-1:0]            pix_now, width_now;
    logic [VW-1:0]            lines_now;
    logic [NUM_D*CSUM_W-1:0]  acc_now;
    logic                     do_lock, do_start, do_end;

    // Edge events on the registered bus
    assign de_rise     = de_r & ~de_d;
    assign de_fall     = ~de_r & de_d;
    assign frame_start = (vsync_d == vs_act) && (vsync_r != vs_act);
    assign frame_end   = (vsync_r == vs_act) && (vsync_d != vs_act);
    assign hs_lead     = (hsync_r == hs_act) && (hsync_d != hs_act);

    // A line closes on de falling, or on frame end while de is still high
    assign pix_now   = (de_r && pix_cnt != '1) ? pix_cnt + HW'(1) : pix_cnt;
    assign line_done = de_fall | (frame_end & de_r);
    assign lines_now = (line_done && line_cnt != '1) ? line_cnt + VW'(1) : line_cnt;
    assign width_now = (line_done && line_cnt == '0) ? pix_now : line_w;
    assign line_bad  = line_done && (line_cnt != '0) && (pix_now != line_w);
    assign limit_hit = (mod_cnt == MOD_W'(FRAME_MAX - 1));

    // Per-channel checksum including the current pixel
    always_comb begin
        acc_now = acc;
        if (de_r) begin
            for (int k = 0; k < int'(NUM_D); k++) begin
                acc_now[k*CSUM_W +: CSUM_W] = acc[k*CSUM_W +: CSUM_W]
                                            + CSUM_W'(data_r[k*DSIZE +: DSIZE]);
            end
        end
    end

    // State register
    always_ff @(posedge opclk or posedge oprst) begin
        if (oprst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        do_lock    = 1'b0;
        do_start   = 1'b0;
        do_end     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_r) state_next = DETECT;
            end
            DETECT: begin
                if (!enable_r) begin
                    state_next = IDLE;
                end else if (de_rise && edge_cnt == EDGE_W'(LOCK_EDGES - 1)) begin
                    do_lock    = 1'b1;
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!enable_r) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    do_start   = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                // enable is only looked at once the frame has completed
                if (frame_end) begin
                    do_end = 1'b1;
                    if (limit_hit && !WRAP_MODE) state_next = DONE;
                    else if (enable_r)           state_next = WAIT_FRAME;
                    else                         state_next = IDLE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Input registers, measurement datapath and result outputs
    always_ff @(posedge opclk or posedge oprst) begin
        if (oprst) begin
            {enable_r, vsync_r, hsync_r, de_r, vsync_d, hsync_d, de_d} <= '0;
            data_r <= '0; edge_cnt <= '0; hs_act <= 1'b0;
            pix_cnt <= '0; line_w <= '0; h_cnt <= '0; line_cnt <= '0;
            acc <= '0; mod_cnt <= '0;
            locked <= 1'b0; vs_act <= 1'b0; frame_cnt <= '0;
            frame_width <= '0; frame_height <= '0; htotal <= '0;
            csum <= '0; csum_valid <= 1'b0; geom_err <= 1'b0; done <= 1'b0;
        end else if (clear) begin
            {enable_r, vsync_r, hsync_r, de_r, vsync_d, hsync_d, de_d} <= '0;
            data_r <= '0; edge_cnt <= '0; hs_act <= 1'b0;
            pix_cnt <= '0; line_w <= '0; h_cnt <= '0; line_cnt <= '0;
            acc <= '0; mod_cnt <= '0;
            locked <= 1'b0; vs_act <= 1'b0; frame_cnt <= '0;
            frame_width <= '0; frame_height <= '0; htotal <= '0;
            csum <= '0; csum_valid <= 1'b0; geom_err <= 1'b0; done <= 1'b0;
        end else begin
            enable_r <= enable;
            vsync_r  <= in_vsync;
            hsync_r  <= in_hsync;
            de_r     <= in_de;
            data_r   <= in_data;
            vsync_d  <= vsync_r;
            hsync_d  <= hsync_r;
            de_d     <= de_r;

            csum_valid <= 1'b0;
            if (WRAP_MODE) done <= 1'b0;

            if (state == IDLE) edge_cnt <= '0;
            else if (state == DETECT && de_rise) edge_cnt <= edge_cnt + EDGE_W'(1);

            // Sync is inactive during active video, so its active level is the inverse
            if (do_lock) begin
                vs_act <= ~vsync_r;
                hs_act <= ~hsync_r;
                locked <= 1'b1;
            end

            // Line period: cycles between hsync leading edges, saturating
            if (locked && state != DONE) begin
                if (hs_lead) begin
                    htotal <= h_cnt;
                    h_cnt  <= HW'(1);
                end else if (h_cnt != '1) begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end

            if (do_start) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                line_w   <= '0;
                acc      <= '0;
            end else if (state == ACTIVE) begin
                pix_cnt  <= line_done ? '0 : pix_now;
                line_cnt <= lines_now;
                line_w   <= width_now;
                acc      <= acc_now;
                if (line_bad) geom_err <= 1'b1;
                if (do_end) begin
                    frame_width  <= width_now;
                    frame_height <= lines_now;
                    csum         <= acc_now;
                    csum_valid   <= 1'b1;
                    frame_cnt    <= frame_cnt + 16'd1;
                    if (frame_cnt != '0 && lines_now != frame_height) geom_err <= 1'b1;
                    mod_cnt <= limit_hit ? '0 : mod_cnt + MOD_W'(1);
                    if (limit_hit) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/video_frame_monitor.md
Name: video_frame_monitor

Overview:
- Synthesizable, self-checking successor to the simulation frame dumper.
- Taps the pixel bus at any point in the video pipeline and detects sync polarity automatically.
- Measures frame geometry and line period, checks that geometry stays constant, and produces per-channel pixel checksums for every frame.
- Counts frames and flags completion after FRAME_MAX frames, in either one-shot or wrapping mode.

Parameters:
- DSIZE, 8, bits per colour channel.
- NUM_D, 3, number of channels packed in in_data; channel k = in_data[k*DSIZE +: DSIZE].
- FRAME_MAX, 20, number of frames before done.
- LOCK_EDGES, 3, de rising edges observed before polarity lock.
- HW, 12, width of horizontal counters.
- VW, 12, width of vertical counters.
- CSUM_W, 32, width of each per-channel checksum.
- STOP_MODE, "ONCE", "ONCE" = halt at FRAME_MAX; "WRAP" = pulse done at every multiple of FRAME_MAX and keep running.

Ports:
- opclk  in  1  pixel clock.
- oprst  in  1  reset, asynchronous, active-high.
- enable  in  1  start monitoring.
- clear  in  1  synchronous clear, same effect as reset.
- in_vsync  in  1  vertical sync, either polarity.
- in_hsync  in  1  horizontal sync, either polarity.
- in_de  in  1  data enable.
- in_data  in  NUM_D*DSIZE  pixel data.
- locked  out  1  polarity detected.
- vs_act  out  1  detected active level of vsync.
- frame_cnt  out  16  completed frames.
- frame_width  out  HW  de-high cycles of the first line of the last frame.
- frame_height  out  VW  lines in the last frame.
- htotal  out  HW  opclk cycles between hsync leading edges.
- csum  out  NUM_D*CSUM_W  per-channel sums for the last frame.
- csum_valid  out  1  one-cycle pulse when the frame results update.
- geom_err  out  1  sticky geometry-mismatch flag.
- done  out  1  frame limit reached.

Behaviour:
- Input registering: all inputs are registered once on the posedge of opclk. All detection uses registered signals and their one-cycle-delayed copies. Outputs therefore lag the pins by 2 cycles.
- Reset / clear: every output and internal register goes to 0 and the state goes to IDLE. clear has priority over all other activity.
- IDLE: stays in IDLE while enable=0; enable=1 -> DETECT.
- DETECT: counts de rising edges.
  - On the LOCK_EDGES-th edge: vs_act <= ~vsync_r and hs_act <= ~hsync_r; locked <= 1; go to WAIT_FRAME.
  - enable=0 -> IDLE.
- WAIT_FRAME: waits for frame start, defined as vsync_r going from vs_act to ~vs_act. On frame start, zero the line, pixel and checksum accumulators and go to ACTIVE. enable=0 -> IDLE.
- ACTIVE, per-cycle rules:
  - de_r=1: pixel counter increments, saturating at all-ones. Each csum channel accumulates modulo 2^CSUM_W.
  - de falling edge: line counter increments, saturating.
    - The first line's pixel count is latched as line width.
    - Any later line with a different count sets geom_err.
  - Frame end is vsync_r entering vs_act.
    - If de_r is still 1 at frame end, the partial line is counted as a line.
    - Outputs update: frame_width, frame_height, csum; csum_valid pulses; frame_cnt increments.
    - If frame_height differs from the previous frame's and frame_cnt was >0 before this frame, set geom_err.
    - A frame with no de yields width 0, height 0, csum 0.
  - Limit check: when frame_cnt reaches FRAME_MAX:
    - ONCE: done <= 1 (held) and go to DONE.
    - WRAP: done pulses one cycle at every multiple of FRAME_MAX, and frame_cnt wraps at 2^16.
  - Otherwise: enable=1 -> WAIT_FRAME; enable=0 -> IDLE.
  - Dropping enable mid-frame does not abort; the current frame completes first.
- DONE: holds all outputs until clear or reset.
- htotal: measured in all states after lock. A free-running counter is captured into htotal and restarted at each hsync_r transition into hs_act. It saturates if no edge arrives.
- Simultaneous frame end and de falling edge: the line is counted before the height is latched.

Test Plan:
- Active-high vsync/hsync, 8x4 frame, 3 frames, data = pixel index 0..31 per channel, FRAME_MAX=20 -> after lock:
  - frame_width=8, frame_height=4, each csum lane=496, one csum_valid per frame, frame_cnt=1,2.
- Same stimulus with inverted syncs -> vs_act=0 and identical results; hsync period 12 -> htotal=12.
- FRAME_MAX=3, ONCE, 6 frames -> done=1 after frame 3; frame_cnt stays 3; no csum_valid afterwards; clear -> all outputs 0.
- WRAP, FRAME_MAX=2, 5 frames -> done pulses after frames 2 and 4 only; frame_cnt=5.
- Frame 2 has one 7-pixel line, frame 3 has 5 lines -> geom_err set in frame 2 and stays set.
- oprst asserted mid-line in ACTIVE -> all outputs 0 immediately; re-lock requires LOCK_EDGES de edges again.
